// File: rtl/dec_serial_adder_pkg.sv
// dec_serial_adder_pkg: shared state encoding and default width
package dec_serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/dec_full_adder.sv
// dec_full_adder: full adder built from a 3-to-8 active-low minterm decode
module dec_full_adder
    import dec_serial_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c,
    output logic s,
    output logic co
);
    logic [7:0] dec_n;
    // one-hot active-low decode of {a_i, b_i, c}
    always_comb begin
        for (int k = 0; k < 8; k++) dec_n[k] = ({a_i, b_i, c} != 3'(k));
    end
    assign s  = ~&{dec_n[1], dec_n[2], dec_n[4], dec_n[7]};
    assign co = ~&{dec_n[3], dec_n[5], dec_n[6], dec_n[7]};
endmodule

// File: rtl/dec_serial_adder.sv
// dec_serial_adder: bit-serial LSB-first add/subtract with gated enables
module dec_serial_adder
    import dec_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             e1,
    input  logic             e2_low,
    input  logic             e3_low,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int IW = $clog2(WIDTH);
    state_t state, next;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-2:0] acc;
    logic [IW-1:0] idx;
    logic carry, en, last, s, co;
    assign en   = e1 & ~e2_low & ~e3_low;
    assign last = (idx == IW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);
    dec_full_adder u_fa (.a_i(ra[idx]), .b_i(rb[idx]), .c(carry), .s(s), .co(co));
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // next-state: DONE always exits, other moves need en
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = (start && en) ? RUN : IDLE;
            RUN:     next = (en && last) ? DONE : RUN;
            default: next = IDLE;
        endcase
    end
    // operand capture, serial datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (en && state == IDLE && start) begin
            ra    <= a;
            rb    <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
        end else if (en && state == RUN) begin
            acc   <= (WIDTH-1)'({s, acc} >> 1);
            carry <= co;
            idx   <= idx + IW'(1);
            if (last) begin
                sum  <= {s, acc};
                cout <= co;
                ovf  <= carry ^ co;
            end
        end
    end
endmodule

// File: doc/dec_serial_adder.md
DEC_SERIAL_ADDER -- requirements
Module: dec_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port e1  input  1  enable, active-high.
REQ-009 SHALL have port e2_low  input  1  enable, active-low.
REQ-010 SHALL have port e3_low  input  1  enable, active-low.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port sum  output  WIDTH  result (two's complement, modulo 2^WIDTH).
REQ-014 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  signed overflow.

Function
REQ-016 SHALL define en = e1 & ~e2_low & ~e3_low; no state advances while en = 0, except reset.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE: start & en at an edge SHALL latch a, b^{WIDTH{sub}}, carry = sub, bit index = 0, and go to RUN.
REQ-019 IDLE: start with en = 0 SHALL be ignored; start in RUN or DONE SHALL be ignored (no queuing).
REQ-020 RUN: each edge with en = 1 SHALL process bit [index] LSB-first via the full-adder cell, shift the sum bit into the result, update carry, increment index.
REQ-021 RUN: edge processing bit WIDTH-1 SHALL go to DONE and register cout = final carry, ovf = carry-into-MSB XOR carry-out-of-MSB.
REQ-022 RUN: edge with en = 0 SHALL hold state, index, carry and partial result unchanged.
REQ-023 DONE SHALL last exactly one cycle regardless of en, assert done = 1, then return to IDLE.
REQ-024 Latency with en held high: start sampled at edge 0 -> busy high cycles 1..WIDTH -> done high in cycle WIDTH+1.
REQ-025 sum, cout, ovf SHALL be updated only on entry to DONE and held until the next DONE or reset; partial results SHALL NOT appear on sum.
REQ-026 The full-adder cell SHALL derive sum/carry from a 3-to-8 one-hot active-low decode of {a_i, b_i, c}: sum = minterms 1,2,4,7; carry = minterms 3,5,6,7.

Reset
REQ-027 rst high SHALL asynchronously force IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, carry = 0, index = 0, including mid-RUN; the operation in progress is discarded.
REQ-028 First edge after rst deasserts SHALL accept start normally.

Structure
REQ-029 Package dec_serial_adder_pkg SHALL hold the state type (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-030 One combinational sub-module, dec_full_adder (inputs a_i, b_i, c; outputs s, co; internal 3-to-8 active-low decode), SHALL be instantiated once.
REQ-031 Index counter width SHALL be $clog2(WIDTH); no other arithmetic operator on the datapath.

Verification (WIDTH=8, en held high unless stated)
REQ-032 a=100, b=27, sub=0 -> done in cycle 9, sum=127, cout=0, ovf=0.
REQ-033 a=200, b=100, sub=0 -> sum=44, cout=1, ovf=0.
REQ-034 a=127, b=1, sub=0 -> sum=128 (0x80), cout=0, ovf=1.
REQ-035 a=5, b=7, sub=1 -> sum=0xFE, cout=0, ovf=0; a second start pulsed during busy is ignored.
REQ-036 a=100, b=27 with e2_low=1 for 3 cycles mid-RUN -> done in cycle 12, sum=127.
REQ-037 rst pulsed in RUN cycle 4 -> busy=0, sum=0 immediately; the next start (a=1, b=1) yields sum=2.
